// File: rtl/alpha_video_pkg.sv
// rtl/alpha_video_pkg.sv - DAC curve constants, pixel types and dither helpers for the RGB888 quantizer
package alpha_video_pkg;

   localparam logic [7:0] DAC_LEVEL [16] = '{
      8'h00, 8'h0B, 8'h1C, 8'h2E, 8'h42, 8'h51, 8'h62, 8'h70,
      8'h92, 8'hA1, 8'hB1, 8'hC0, 8'hD4, 8'hE3, 8'hF4, 8'hFF
   };

   // Midpoints between adjacent levels, rounded up so ties select the upper code.
   localparam logic [7:0] DAC_THRESH [15] = '{
      8'h06, 8'h14, 8'h25, 8'h38, 8'h4A, 8'h5A, 8'h69, 8'h81,
      8'h9A, 8'hA9, 8'hB9, 8'hCA, 8'hDC, 8'hEC, 8'hFA
   };

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   // Indexed by {py, px}.
   localparam logic signed [9:0] DITHER_OFF [4] = '{-10'sd6, 10'sd2, 10'sd6, -10'sd2};

   function automatic logic [7:0] sat_add(input logic [7:0] v, input logic signed [9:0] off);
      logic signed [9:0] s;
      s = $signed({2'b00, v}) + off;
      if (s < 10'sd0) return 8'h00;
      if (s > 10'sd255) return 8'hFF;
      return s[7:0];
   endfunction

endpackage

// File: rtl/quant_stage.sv
// rtl/quant_stage.sv - one binary-search step deciding code bit BIT for a single channel
module quant_stage
   import alpha_video_pkg::*;
#(
   parameter int BIT = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       adv,
   input  logic       in_valid,
   input  logic [7:0] in_val,
   input  logic [3:0] in_code,
   output logic       out_valid,
   output logic [7:0] out_val,
   output logic [3:0] out_code
);

   logic       valid_q, valid_d;
   logic [7:0] val_q, val_d;
   logic [3:0] code_q, code_d;
   logic [3:0] cand;
   logic [7:0] thr;

   always_comb begin
      cand      = in_code;
      cand[BIT] = 1'b1;
      thr       = DAC_THRESH[cand - 4'd1];
      valid_d   = valid_q;
      val_d     = val_q;
      code_d    = code_q;
      if (adv) begin
         valid_d = in_valid;
         val_d   = in_val;
         code_d  = (in_val >= thr) ? cand : in_code;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         val_q   <= '0;
         code_q  <= '0;
      end else begin
         valid_q <= valid_d;
         val_q   <= val_d;
         code_q  <= code_d;
      end
   end

   assign out_valid = valid_q;
   assign out_val   = val_q;
   assign out_code  = code_q;

endmodule

// File: rtl/rgb888_to_dac4_quantizer.sv
// rtl/rgb888_to_dac4_quantizer.sv - 4-stage pipelined RGB888 to 4-bit DAC code quantizer
// Optional 2x2 ordered dither ahead of the first stage when RGB_QUANT_DITHER_EN is defined.
module rgb888_to_dac4_quantizer
   import alpha_video_pkg::*;
#(
   parameter int SB_W = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [23:0]     in_rgb,
   input  logic [SB_W-1:0] in_sb,
   input  logic            in_sof,
   input  logic            in_eol,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [11:0]     out_rgb4,
   output logic [SB_W-1:0] out_sb
);

   logic [4:0][2:0][7:0] val_w;
   logic [4:0][2:0][3:0] code_w;
   logic [4:0][2:0]      vld_w;
   logic                 adv;
   rgb888_t              pix;
   logic [SB_W-1:0]      sb_q [4];
   logic [SB_W-1:0]      sb_d [4];

   assign adv      = !(&vld_w[4]) || out_ready;
   assign in_ready = adv;

`ifdef RGB_QUANT_DITHER_EN
   logic                px_q, px_d, py_q, py_d, px_e, py_e;
   logic signed [9:0]   off;

   always_comb begin
      px_e  = in_sof ? 1'b0 : px_q;
      py_e  = in_sof ? 1'b0 : py_q;
      off   = DITHER_OFF[{py_e, px_e}];
      pix.r = sat_add(in_rgb[23:16], off);
      pix.g = sat_add(in_rgb[15:8], off);
      pix.b = sat_add(in_rgb[7:0], off);
      px_d  = px_q;
      py_d  = py_q;
      // Parity only moves on beats that actually enter the pipeline.
      if (in_valid && adv) begin
         px_d = in_eol ? 1'b0 : !px_e;
         py_d = in_eol ? !py_e : py_e;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         px_q <= 1'b0;
         py_q <= 1'b0;
      end else begin
         px_q <= px_d;
         py_q <= py_d;
      end
   end
`else
   logic unused_frame;
   assign unused_frame = in_sof ^ in_eol;
   assign pix          = in_rgb;
`endif

   assign val_w[0]  = {pix.r, pix.g, pix.b};
   assign code_w[0] = '0;
   assign vld_w[0]  = {3{in_valid}};

   for (genvar s = 0; s < 4; s++) begin : g_stage
      for (genvar c = 0; c < 3; c++) begin : g_ch
         quant_stage #(.BIT(3 - s)) u_stage (
            .clk      (clk),
            .reset_n  (reset_n),
            .adv      (adv),
            .in_valid (vld_w[s][c]),
            .in_val   (val_w[s][c]),
            .in_code  (code_w[s][c]),
            .out_valid(vld_w[s+1][c]),
            .out_val  (val_w[s+1][c]),
            .out_code (code_w[s+1][c])
         );
      end
   end

   always_comb begin
      sb_d = sb_q;
      if (adv) begin
         sb_d[0] = in_sb;
         for (int i = 1; i < 4; i++) sb_d[i] = sb_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) sb_q[i] <= '0;
      end else begin
         sb_q <= sb_d;
      end
   end

   logic unused_val;
   assign unused_val = ^val_w[4];

   assign out_valid = &vld_w[4];
   assign out_rgb4  = code_w[4];
   assign out_sb    = sb_q[3];

endmodule
